hamming_enc_stream: RTL

- Parametrised, pipelined Hamming encoder; successor to the combinational 4-bit odd-parity (7,4) encoder.
- Supports any data width, runtime odd/even parity selection and an optional SEC-DED overall parity bit.
- Sits between a data source and a channel/serialiser, with a valid/ready stream on both sides.
- Also provides single-bit error injection and an encoded-word counter for link and decoder testing.

---
 rtl/hamming_enc_stream.sv | 116 +++++++++++
 1 files changed

// File: rtl/hamming_enc_stream.sv
// Pipelined Hamming encoder with valid/ready stream, runtime odd/even parity, optional
// SEC-DED overall bit, single-bit error injection and a delivered-codeword counter.
module hamming_enc_stream #(
  parameter int DATA_W  = 11,
  parameter int EXT_PAR = 1,
  parameter int CNT_W   = 16,
  // Smallest R with 2^R >= DATA_W+R+1, tabulated for DATA_W up to 2036
  localparam int PAR_W = (DATA_W <= 1)    ? 2  :
                         (DATA_W <= 4)    ? 3  :
                         (DATA_W <= 11)   ? 4  :
                         (DATA_W <= 26)   ? 5  :
                         (DATA_W <= 57)   ? 6  :
                         (DATA_W <= 120)  ? 7  :
                         (DATA_W <= 247)  ? 8  :
                         (DATA_W <= 502)  ? 9  :
                         (DATA_W <= 1013) ? 10 : 11,
  localparam int CW_W  = DATA_W + PAR_W + EXT_PAR,
  localparam int POS_W = $clog2(CW_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              odd_par,
  input  logic              inj_en,
  input  logic [POS_W-1:0]  inj_pos,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CW_W-1:0]   out_data,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  word_cnt
);

  localparam int HAM_N = DATA_W + PAR_W;

  logic [CW_W-1:0]  r_data;
  logic             r_valid;
  logic [CNT_W-1:0] r_cnt;

  logic [CW_W-1:0]  w_cw;
  logic [CW_W-1:0]  w_flip;
  logic             w_par;
  logic             w_accept;
  logic             w_out_hs;

  // Codeword index (position-1) of data bit idx: the idx-th non-power-of-two position.
  function automatic int data_pos(input int idx);
    int seen;
    int res;
    seen = 0;
    res  = 0;
    for (int k = 0; k < HAM_N; k++) begin
      if (((k + 1) & k) != 0) begin
        if (seen == idx) res = k;
        seen++;
      end
    end
    return res;
  endfunction

  always_comb begin
    w_cw  = '0;
    w_par = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      w_cw[data_pos(i)] = in_data[i];
    end
    // Parity slots are still zero here, so each group sums only its data positions.
    for (int j = 0; j < PAR_W; j++) begin
      w_par = odd_par;
      for (int k = 0; k < HAM_N; k++) begin
        if ((((k + 1) >> j) & 1) == 1) w_par = w_par ^ w_cw[k];
      end
      w_cw[(1 << j) - 1] = w_par;
    end
    if (EXT_PAR != 0) begin
      w_cw[CW_W-1] = (^w_cw[CW_W-2:0]) ^ odd_par;
    end
  end

  // Shifting past the top bit yields zero, so out-of-range positions leave the word clean.
  assign w_flip = {{(CW_W-1){1'b0}}, inj_en} << inj_pos;

  assign in_ready = !r_valid || out_ready;
  assign w_accept = in_valid && in_ready;
  assign w_out_hs = r_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_data  <= w_cw ^ w_flip;
        r_valid <= 1'b1;
      end else if (w_out_hs) begin
        r_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (cnt_clr) begin
      r_cnt <= '0;
    end else if (w_out_hs) begin
      r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign word_cnt  = r_cnt;

endmodule
